// File: rtl/ddr2_line_responder.sv
// Simulation/bring-up stand-in for the DDR2 controller: queues 128-bit line
// write-backs and fills and serves them in order from a 32-bit word array.
module ddr2_line_responder #(
  parameter int MEM_AW = 14,
  parameter int LAT    = 4,
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [26:0]  ddr2_addr,
  input  logic [127:0] to_ddr2_data,
  input  logic         ddr2_enable,
  input  logic         ddr2_read,
  output logic [127:0] ddr2_data,
  output logic         ddr2_available,
  output logic         busy,
  output logic         err_overflow
);

  localparam int LW  = MEM_AW - 2;
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CTW = $clog2(QDEPTH + 1);
  localparam int CNW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DRAIN} state_t;

  state_t          state;
  logic [LW-1:0]   q_line [QDEPTH];
  logic            q_read [QDEPTH];
  logic [127:0]    q_data [QDEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CTW-1:0]  count;
  logic            pop;
  logic            push;
  logic [LW-1:0]   cur_line;
  logic            cur_read;
  logic [127:0]    cur_data;
  logic [CNW-1:0]  cnt;
  logic [1:0]      beat;
  logic [31:0]     mem [2**MEM_AW];
  logic [31:0]     mem_q;
  logic [95:0]     line_buf;
  logic [MEM_AW-1:0] word_addr;
  logic            mem_we;
  logic            unused_addr_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full queue still accepts a push on the edge where the FSM pops its head.
  assign pop    = (state == IDLE) && (count != '0);
  assign push   = ddr2_enable && ((count != CTW'(QDEPTH)) || pop);
  assign busy   = (state != IDLE) || (count != '0);
  assign word_addr = {cur_line, beat};
  assign mem_we = (state == BEAT) && !cur_read;
  assign unused_addr_bits = ^{ddr2_addr[26:MEM_AW+2], ddr2_addr[3:0]};

  always_ff @(posedge clk) begin
    if (push) begin
      q_line[tail] <= ddr2_addr[MEM_AW+1:4];
      q_read[tail] <= ddr2_read;
      q_data[tail] <= to_ddr2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      if (push && !pop)
        count <= count + CTW'(1);
      else if (pop && !push)
        count <= count - CTW'(1);
      if (ddr2_enable && !push) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      beat           <= 2'd0;
      cur_line       <= '0;
      cur_read       <= 1'b0;
      cur_data       <= '0;
      line_buf       <= '0;
      ddr2_data      <= '0;
      ddr2_available <= 1'b0;
    end else begin
      ddr2_available <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_line <= q_line[head];
            cur_read <= q_read[head];
            cur_data <= q_data[head];
            beat     <= 2'd0;
            if (LAT == 0) begin
              state <= BEAT;
            end else begin
              state <= WAIT;
              cnt   <= CNW'(LAT - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= BEAT;
          else           cnt   <= cnt - CNW'(1);
        end
        BEAT: begin
          // Read data lags the address by one edge, so beat i stores word i-1.
          if (cur_read && (beat != 2'd0))
            line_buf <= {mem_q, line_buf[95:32]};
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= cur_read ? DRAIN : IDLE;
        end
        DRAIN: begin
          ddr2_data      <= {mem_q, line_buf};
          ddr2_available <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_addr] <= cur_data[32*beat +: 32];
    mem_q <= mem[word_addr];
  end

endmodule

// File: tb/tb_ddr2_line_responder.sv
// Directed bench for ddr2_line_responder: a LAT=4 instance for most scenarios
// and a LAT=0 instance for the aliasing/zero-latency case, with fill scoreboards.
module tb_ddr2_line_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [26:0]  addr, addr0;
  logic [127:0] wdata, wdata0;
  logic         en, en0, rd, rd0;
  logic [127:0] data, data0;
  logic         avail, avail0, busy, busy0, ovf, ovf0;

  ddr2_line_responder #(.MEM_AW(14), .LAT(4), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .ddr2_addr(addr), .to_ddr2_data(wdata),
    .ddr2_enable(en), .ddr2_read(rd), .ddr2_data(data),
    .ddr2_available(avail), .busy(busy), .err_overflow(ovf)
  );

  ddr2_line_responder #(.MEM_AW(14), .LAT(0), .QDEPTH(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .ddr2_addr(addr0), .to_ddr2_data(wdata0),
    .ddr2_enable(en0), .ddr2_read(rd0), .ddr2_data(data0),
    .ddr2_available(avail0), .busy(busy0), .err_overflow(ovf0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int pulses0  = 0;
  logic [31:0]  mem_m  [int];
  logic [31:0]  mem_m0 [int];
  logic [127:0] exp_q  [$];
  logic [127:0] exp_q0 [$];

  localparam logic [127:0] L1 = 128'h4444_3333_2222_1111;
  localparam logic [127:0] L2 = 128'hA2A2_0002_B2B2_0001_C2C2_0000_D2D2_FFFF;
  localparam logic [127:0] L3 = 128'h3333_AAAA_5555_CCCC_0F0F_F0F0_1234_5678;
  localparam logic [127:0] L4 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FEED_FACE;
  localparam logic [127:0] L5 = 128'h5555_0004_5555_0003_5555_0002_5555_0001;

  function automatic int word_idx(input logic [26:0] a, input int b);
    return int'(a[15:4]) * 4 + b;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request for the coming edge and updates the reference model if accepted.
  task automatic applyStimulus(input bit sel, input logic [26:0] a, input bit r,
                               input logic [127:0] d, input bit acc);
    logic [127:0] line;
    int w;
    if (!sel) begin addr = a; rd = r; wdata = d; en = 1'b1; end
    else      begin addr0 = a; rd0 = r; wdata0 = d; en0 = 1'b1; end
    if (acc) begin
      line = '0;
      for (int b = 0; b < 4; b++) begin
        w = word_idx(a, b);
        if (r) begin
          if (!sel) line[32*b +: 32] = mem_m.exists(w)  ? mem_m[w]  : 32'h0;
          else      line[32*b +: 32] = mem_m0.exists(w) ? mem_m0[w] : 32'h0;
        end else begin
          if (!sel) mem_m[w]  = d[32*b +: 32];
          else      mem_m0[w] = d[32*b +: 32];
        end
      end
      if (r) begin
        if (!sel) exp_q.push_back(line);
        else      exp_q0.push_back(line);
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || busy0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 128'(busy | busy0), 128'(0));
    @(negedge clk);
  endtask

  task automatic measure(input bit sel, output int cyc);
    cyc = -1;
    for (int n = 0; n < 40; n++) begin
      if ((!sel && avail) || (sel && avail0)) begin
        cyc = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (avail) begin
      pulses++;
      checkOutput("fill_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) checkOutput("fill_data", data, exp_q.pop_front());
    end
    if (avail0) begin
      pulses0++;
      checkOutput("fill0_expected", 128'(exp_q0.size() != 0), 128'(1));
      if (exp_q0.size() != 0) checkOutput("fill0_data", data0, exp_q0.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int cyc, p;
    rst_n = 1'b0;
    en = 0; en0 = 0; rd = 0; rd0 = 0;
    addr = '0; addr0 = '0; wdata = '0; wdata0 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_data", data, 128'(0));
    checkOutput("rst_avail", 128'(avail), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_ovf", 128'(ovf), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] write then idle read, latency LAT+6");
    applyStimulus(0, 27'h0000100, 0, L1, 1); en = 0;
    wait_idle();
    applyStimulus(0, 27'h0000100, 1, '0, 1); en = 0;
    measure(0, cyc);
    checkOutput("t1_latency", 128'(cyc), 128'(10));
    @(negedge clk);
    checkOutput("t1_pulse_width", 128'(avail), 128'(0));
    repeat (3) @(negedge clk);
    checkOutput("t1_hold", data, L1);
    wait_idle();

    $display("[TB] write-back then fill on next cycle");
    applyStimulus(0, 27'h0000010, 0, L2, 1); en = 0;
    wait_idle();
    p = pulses;
    applyStimulus(0, 27'h0004010, 0, L3, 1);
    applyStimulus(0, 27'h0000010, 1, '0, 1); en = 0;
    wait_idle();
    checkOutput("t2_ovf", 128'(ovf), 128'(0));
    checkOutput("t2_pulses", 128'(pulses), 128'(p + 1));
    checkOutput("t2_data", data, L2);

    $display("[TB] push on the pop edge with queue full");
    p = pulses;
    applyStimulus(0, 27'h0000200, 0, L4, 1);
    applyStimulus(0, 27'h0000100, 1, '0, 1);
    applyStimulus(0, 27'h0000010, 1, '0, 1); en = 0;
    repeat (7) @(negedge clk);
    applyStimulus(0, 27'h0000200, 1, '0, 1); en = 0;
    checkOutput("t6_ovf", 128'(ovf), 128'(0));
    wait_idle();
    checkOutput("t6_pulses", 128'(pulses), 128'(p + 3));
    checkOutput("t6_last_data", data, L4);

    $display("[TB] three pushes during WAIT");
    p = pulses;
    applyStimulus(0, 27'h0000100, 1, '0, 1); en = 0;
    @(negedge clk);
    applyStimulus(0, 27'h0000010, 1, '0, 1);
    applyStimulus(0, 27'h0004010, 1, '0, 1);
    applyStimulus(0, 27'h0000200, 1, '0, 0); en = 0;
    checkOutput("t3_ovf_set", 128'(ovf), 128'(1));
    wait_idle();
    checkOutput("t3_pulses", 128'(pulses), 128'(p + 3));
    checkOutput("t3_ovf_sticky", 128'(ovf), 128'(1));
    checkOutput("t3_last_data", data, L3);

    $display("[TB] reset during beat 2 of a read");
    applyStimulus(0, 27'h0000200, 1, '0, 1); en = 0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_data", data, 128'(0));
    checkOutput("t4_avail", 128'(avail), 128'(0));
    checkOutput("t4_busy", 128'(busy), 128'(0));
    checkOutput("t4_ovf", 128'(ovf), 128'(0));
    exp_q.delete();
    p = pulses;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("t4_no_pulse", 128'(pulses), 128'(p));
    checkOutput("t4_busy_after", 128'(busy), 128'(0));
    applyStimulus(0, 27'h0000100, 1, '0, 1); en = 0;
    wait_idle();
    checkOutput("t4_recover_pulses", 128'(pulses), 128'(p + 1));
    checkOutput("t4_recover_data", data, L1);

    $display("[TB] LAT=0 aliasing");
    applyStimulus(1, 27'h0000100, 0, L5, 1); en0 = 0;
    wait_idle();
    applyStimulus(1, 27'h4000100, 1, '0, 1); en0 = 0;
    measure(1, cyc);
    checkOutput("t5_latency", 128'(cyc), 128'(6));
    checkOutput("t5_alias_data", data0, L5);
    wait_idle();
    applyStimulus(1, 27'h400010F, 1, '0, 1); en0 = 0;
    measure(1, cyc);
    checkOutput("t5_low_bits_latency", 128'(cyc), 128'(6));
    checkOutput("t5_low_bits_data", data0, L5);
    wait_idle();
    checkOutput("t5_pulses", 128'(pulses0), 128'(2));
    checkOutput("scoreboard_empty", 128'(exp_q.size() + exp_q0.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
